y_alu_bist: RTL and testbench

Built-in self-test sequencer for the 32-bit `yAlu` datapath. It is the stimulus and checking side of the ALU interface.

- Generates pseudo-random operand pairs from an LFSR and drives them into an external `yAlu` instance across all five supported operations.
- Compares the ALU result and zero flag against an internal oracle.
- Reports pass/fail counts and the first failing vector.

It sits beside `yAlu` in the datapath test harness and replaces the software testbench loop with synthesizable hardware.

---
 rtl/y_alu_bist.sv | 146 ++++++++++++++
 tb/tb_y_alu_bist.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/y_alu_bist.sv
// Built-in self-test sequencer for a 32-bit yAlu: drives LFSR operands through
// AND/OR/ADD/SUB/SLT, checks result and zero flag, and records the first failure.
module y_alu_bist #(
   parameter int          VECTORS = 3,
   parameter logic [31:0] SEED    = 32'hACE1_2021
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_z,
   input  logic        alu_ex,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [10:0] fail_cnt,
   output logic [2:0]  first_fail_op,
   output logic [7:0]  first_fail_idx,
   output logic [31:0] first_fail_z
);

   // state | meaning
   // IDLE  | waiting for start after reset
   // GEN_A | load operand a from the LFSR
   // GEN_B | load operand b (random or a copy of a), ALU settles next cycle
   // CHECK | compare ALU result/zero flag against the oracle
   // DONE  | run finished, results held until the next start
   typedef enum logic [2:0] {IDLE, GEN_A, GEN_B, CHECK, DONE} state_t;

   localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [31:0] MASK     = 32'h8020_0003;
   localparam logic [7:0]  LAST_IDX = 8'(VECTORS - 1);
   localparam logic [2:0]  OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                           OP_SUB = 3'b110, OP_SLT = 3'b111;
   localparam logic [10:0] FAIL_MAX = 11'd2047;

   state_t      state;
   logic [31:0] lfsr;
   logic [7:0]  idx;
   logic [31:0] expect_z;
   logic        vec_fail;
   logic [10:0] fail_next;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? MASK : 32'd0);
   endfunction

   function automatic logic [31:0] oracle(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [2:0] next_op(input logic [2:0] op);
      case (op)
         OP_AND:  return OP_OR;
         OP_OR:   return OP_ADD;
         OP_ADD:  return OP_SUB;
         default: return OP_SLT;
      endcase
   endfunction

   always_comb begin
      expect_z  = oracle(alu_a, alu_b, alu_op);
      vec_fail  = (alu_z != expect_z) || (alu_ex != (expect_z == 32'd0));
      fail_next = fail_cnt;
      if (vec_fail && fail_cnt != FAIL_MAX) fail_next = fail_cnt + 11'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         lfsr           <= SEED_EFF;
         idx            <= 8'd0;
         alu_a          <= 32'd0;
         alu_b          <= 32'd0;
         alu_op         <= OP_AND;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_cnt       <= 11'd0;
         first_fail_op  <= 3'd0;
         first_fail_idx <= 8'd0;
         first_fail_z   <= 32'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= GEN_A;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail_cnt       <= 11'd0;
                  first_fail_op  <= 3'd0;
                  first_fail_idx <= 8'd0;
                  first_fail_z   <= 32'd0;
                  idx            <= 8'd0;
                  alu_op         <= OP_AND;
               end
            end
            GEN_A: begin
               alu_a <= lfsr;
               lfsr  <= lfsr_step(lfsr);
               state <= GEN_B;
            end
            GEN_B: begin
               // MSB-gated copy forces a == b on roughly half the vectors
               alu_b <= lfsr[31] ? lfsr : alu_a;
               lfsr  <= lfsr_step(lfsr);
               state <= CHECK;
            end
            CHECK: begin
               fail_cnt <= fail_next;
               if (vec_fail && fail_cnt == 11'd0) begin
                  first_fail_op  <= alu_op;
                  first_fail_idx <= idx;
                  first_fail_z   <= alu_z;
               end
               if (idx < LAST_IDX) begin
                  idx   <= idx + 8'd1;
                  state <= GEN_A;
               end else if (alu_op == OP_SLT) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_next == 11'd0);
               end else begin
                  idx    <= 8'd0;
                  alu_op <= next_op(alu_op);
                  state  <= GEN_A;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_y_alu_bist.sv
// Self-checking bench for y_alu_bist: behavioural yAlu with injectable faults,
// a reference LFSR that predicts every vector, and a scoreboard of expected operands.
module tb_y_alu_bist;

   localparam int          V    = 3;
   localparam logic [31:0] SEED = 32'hACE1_2021;
   localparam logic [31:0] MASK = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] alu_a, alu_b, alu_z;
   logic [2:0]  alu_op;
   logic        alu_ex;
   logic        busy, done, pass;
   logic [10:0] fail_cnt;
   logic [2:0]  first_fail_op;
   logic [7:0]  first_fail_idx;
   logic [31:0] first_fail_z;

   int n_checks = 0;
   int n_pass   = 0;
   int fault_mode = 0;   // 0 clean, 1 z[0] stuck-0 on ADD, 2 inverted ex, 3 unsigned SLT

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
   } vec_t;
   vec_t        sb[$];
   logic [31:0] m_lfsr;

   y_alu_bist #(.VECTORS(V), .SEED(SEED)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_z(alu_z), .alu_ex(alu_ex),
      .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
      .first_fail_op(first_fail_op), .first_fail_idx(first_fail_idx),
      .first_fail_z(first_fail_z)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? MASK : 32'd0);
   endfunction

   function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // yAlu with optional planted faults; returns {ex, z}
   function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input int mode);
      logic [31:0] z;
      logic        ex;
      z = golden(a, b, op);
      if (mode == 3 && op == 3'b111) z = (a < b) ? 32'd1 : 32'd0;
      ex = (z == 32'd0);
      if (mode == 1 && op == 3'b010) z[0] = 1'b0;
      if (mode == 2) ex = ~ex;
      return {ex, z};
   endfunction

   always_comb begin
      {alu_ex, alu_z} = alu_model(alu_a, alu_b, alu_op, fault_mode);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic run(input int mode, input int ignore_at, input int abort_at);
      logic [2:0]  ops [5];
      logic [31:0] a, b, g;
      logic [32:0] r;
      vec_t        v;
      int          e_cnt;
      logic [2:0]  e_op;
      logic [7:0]  e_idx;
      logic [31:0] e_z;
      ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
      e_cnt = 0; e_op = 3'd0; e_idx = 8'd0; e_z = 32'd0;
      fault_mode = mode;
      sb.delete();
      for (int o = 0; o < 5; o++) begin
         for (int i = 0; i < V; i++) begin
            a = m_lfsr;
            m_lfsr = step(m_lfsr);
            b = m_lfsr[31] ? m_lfsr : a;
            m_lfsr = step(m_lfsr);
            v.a = a; v.b = b; v.op = ops[o];
            sb.push_back(v);
            g = golden(a, b, ops[o]);
            r = alu_model(a, b, ops[o], mode);
            if (r[31:0] != g || r[32] != (g == 32'd0)) begin
               if (e_cnt == 0) begin
                  e_op = ops[o]; e_idx = 8'(i); e_z = r[31:0];
               end
               if (e_cnt < 2047) e_cnt++;
            end
         end
      end

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_clears_on_start", {63'd0, done}, 64'd0);
      chk("busy_after_start", {63'd0, busy}, 64'd1);

      for (int k = 0; k < 5 * V; k++) begin
         if (k == ignore_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         v = sb.pop_front();
         chk("vec_a", {32'd0, alu_a}, {32'd0, v.a});
         chk("vec_b", {32'd0, alu_b}, {32'd0, v.b});
         chk("vec_op", {61'd0, alu_op}, {61'd0, v.op});
         chk("busy_in_check", {63'd0, busy}, 64'd1);
         if (k == abort_at) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            chk("abort_busy", {63'd0, busy}, 64'd0);
            chk("abort_done", {63'd0, done}, 64'd0);
            chk("abort_fail_cnt", {53'd0, fail_cnt}, 64'd0);
            m_lfsr = SEED;
            sb.delete();
            return;
         end
         @(negedge clk);
      end

      chk("end_busy", {63'd0, busy}, 64'd0);
      chk("end_done", {63'd0, done}, 64'd1);
      chk("end_pass", {63'd0, pass}, {63'd0, e_cnt == 0});
      chk("end_fail_cnt", {53'd0, fail_cnt}, 64'(e_cnt));
      chk("first_fail_op", {61'd0, first_fail_op}, {61'd0, e_op});
      chk("first_fail_idx", {56'd0, first_fail_idx}, {56'd0, e_idx});
      chk("first_fail_z", {32'd0, first_fail_z}, {32'd0, e_z});
      @(negedge clk);
      chk("done_sticky", {63'd0, done}, 64'd1);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b1;   // reset must win over start
      m_lfsr  = SEED;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done_pass", {62'd0, done, pass}, 64'd0);
      chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
      chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
      chk("rst_alu_op", {61'd0, alu_op}, 64'd0);
      chk("rst_fail_cnt", {53'd0, fail_cnt}, 64'd0);
      chk("rst_first_fail", {21'd0, first_fail_op, first_fail_idx, first_fail_z}, 64'd0);
      start   = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_holds", {63'd0, busy}, 64'd0);

      run(0, -1, -1);   // clean run
      run(0, 3, -1);    // start pulsed mid-run must be ignored
      run(0, -1, 6);    // reset mid-run
      run(0, -1, -1);   // LFSR restarted from SEED after reset
      run(1, -1, -1);   // result stuck-at on ADD
      run(2, -1, -1);   // inverted zero flag
      run(3, -1, -1);   // unsigned SLT in the ALU

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
